// File: rtl/mmio_hub.sv
`default_nettype none
// ============================================================================
// Module   : mmio_hub
// Brief    : 32-byte MMIO window with hex, LEDs, switches, debounced buttons
//            with sticky edge capture, and a free-running timer/compare.
// Revision : 1.0
// ============================================================================
module mmio_hub #(
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0000,
    parameter int          NUM_SW          = 16,
    parameter int          NUM_BTNS        = 5,
    parameter int          NUM_LEDS        = 16,
    parameter int          NUM_DIGITS      = 4,
    parameter int          DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    memread,
    input  logic                    memwrite,
    input  logic [31:0]             addr,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    input  logic [NUM_SW-1:0]       sw,
    input  logic [NUM_BTNS-1:0]     btn,
    output logic [4*NUM_DIGITS-1:0] hex,
    output logic [NUM_LEDS-1:0]     led,
    output logic                    irq
);

    localparam int                 c_HEX_W   = 4 * NUM_DIGITS;
    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [31:0]         r_readdata;
    logic [c_HEX_W-1:0]  r_hex;
    logic [NUM_LEDS-1:0] r_led;
    logic [NUM_SW-1:0]   r_sw_meta, r_sw_sync;
    logic [NUM_BTNS-1:0] r_btn_meta, r_btn_sync;
    logic [NUM_BTNS-1:0] r_btn_edge;
    logic [31:0]         r_timer, r_cmp;
    logic                r_match;

    logic [NUM_BTNS-1:0] w_btn_db, w_btn_rise;
    logic [31:0]         w_rd_mux;
    logic                w_hit, w_wr;
    logic [2:0]          w_idx;

    // addr[1:0] is don't-care and upper writedata bits go unused for narrow registers
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, addr[1:0], writedata};

    assign w_hit = (addr[31:5] == BASE_ADDR[31:5]);
    assign w_idx = addr[4:2];
    assign w_wr  = memwrite & w_hit;

    assign hex = r_hex;
    assign led = r_led;
    assign irq = r_match;
    assign readdata = r_readdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_btn_meta <= '0;
            r_btn_sync <= '0;
        end else begin
            r_sw_meta  <= sw;
            r_sw_sync  <= r_sw_meta;
            r_btn_meta <= btn;
            r_btn_sync <= r_btn_meta;
        end
    end

    // Per-button debouncer: a level flips only after staying different long enough
    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_debounce
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_level;
        logic               w_flip;

        assign w_flip        = (r_btn_sync[i] != r_level) && (r_cnt == c_CNT_MAX);
        assign w_btn_db[i]   = r_level;
        assign w_btn_rise[i] = w_flip & ~r_level;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
            end else if (r_btn_sync[i] == r_level) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_cnt   <= '0;
                r_level <= ~r_level;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_idx)
            3'd0:    w_rd_mux = 32'(r_hex);
            3'd1:    w_rd_mux = 32'(r_led);
            3'd2:    w_rd_mux = 32'(r_sw_sync);
            3'd3:    w_rd_mux = 32'(w_btn_db);
            3'd4:    w_rd_mux = 32'(r_btn_edge);
            3'd5:    w_rd_mux = r_timer;
            3'd6:    w_rd_mux = r_cmp;
            default: w_rd_mux = {31'd0, r_match};
        endcase
    end

    // Sticky flags: a same-cycle set overrides the write-one-to-clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_readdata <= '0;
            r_hex      <= '0;
            r_led      <= '0;
            r_btn_edge <= '0;
            r_timer    <= '0;
            r_cmp      <= 32'hFFFF_FFFF;
            r_match    <= 1'b0;
        end else begin
            if (memread) begin
                r_readdata <= w_hit ? w_rd_mux : 32'd0;
            end
            if (w_wr && w_idx == 3'd0) begin
                r_hex <= writedata[c_HEX_W-1:0];
            end
            if (w_wr && w_idx == 3'd1) begin
                r_led <= writedata[NUM_LEDS-1:0];
            end
            if (w_wr && w_idx == 3'd4) begin
                r_btn_edge <= (r_btn_edge & ~writedata[NUM_BTNS-1:0]) | w_btn_rise;
            end else begin
                r_btn_edge <= r_btn_edge | w_btn_rise;
            end
            if (w_wr && w_idx == 3'd5) begin
                r_timer <= writedata;
            end else begin
                r_timer <= r_timer + 32'd1;
            end
            if (w_wr && w_idx == 3'd6) begin
                r_cmp <= writedata;
            end
            r_match <= (r_match & ~(w_wr && w_idx == 3'd7 && writedata[0]))
                     | (r_timer == r_cmp);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_hub.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_hub
// Brief    : Directed scoreboard bench for mmio_hub with a short debounce.
// Revision : 1.0
// ============================================================================
module tb_mmio_hub;

    localparam logic [31:0] c_BASE   = 32'hFFFF_0000;
    localparam logic [31:0] c_HEX    = c_BASE + 32'h00;
    localparam logic [31:0] c_LED    = c_BASE + 32'h04;
    localparam logic [31:0] c_SW     = c_BASE + 32'h08;
    localparam logic [31:0] c_BTN    = c_BASE + 32'h0C;
    localparam logic [31:0] c_EDGE   = c_BASE + 32'h10;
    localparam logic [31:0] c_TIMER  = c_BASE + 32'h14;
    localparam logic [31:0] c_CMP    = c_BASE + 32'h18;
    localparam logic [31:0] c_STATUS = c_BASE + 32'h1C;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [15:0] sw = '0;
    logic [4:0]  btn = '0;
    logic [15:0] hex;
    logic [15:0] led;
    logic        irq;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    mmio_hub #(
        .BASE_ADDR      (c_BASE),
        .NUM_SW         (16),
        .NUM_BTNS       (5),
        .NUM_LEDS       (16),
        .NUM_DIGITS     (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .memread  (memread),
        .memwrite (memwrite),
        .addr     (addr),
        .writedata(writedata),
        .readdata (readdata),
        .sw       (sw),
        .btn      (btn),
        .hex      (hex),
        .led      (led),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        memread = 1'b1;
        addr    = a;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk); #1;
        memread = 1'b0;
        check(tag_q.pop_front(), readdata, exp_q.pop_front());
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        addr      = a;
        writedata = d;
        @(posedge clk); #1;
        memwrite = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        idle(3);
        check("rst_readdata", readdata, 32'd0);
        check("rst_hex", 32'(hex), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        reset = 1'b1;
        do_read(c_TIMER,  32'd0,         "rd_timer0");
        do_read(c_HEX,    32'd0,         "rd_hex0");
        do_read(c_LED,    32'd0,         "rd_led0");
        do_read(c_SW,     32'd0,         "rd_sw0");
        do_read(c_BTN,    32'd0,         "rd_btn0");
        do_read(c_EDGE,   32'd0,         "rd_edge0");
        do_read(c_CMP,    32'hFFFF_FFFF, "rd_cmp0");
        do_read(c_STATUS, 32'd0,         "rd_status0");

        // HEX / LED write and readback
        do_write(c_HEX, 32'h0000_BEEF);
        check("hex_wr", 32'(hex), 32'h0000_BEEF);
        do_write(c_LED, 32'h0000_A5A5);
        check("led_wr", 32'(led), 32'h0000_A5A5);
        do_read(c_HEX, 32'h0000_BEEF, "rd_hex");
        do_read(c_LED, 32'h0000_A5A5, "rd_led");

        // Short button pulse is rejected
        btn[2] = 1'b1;
        idle(3);
        btn[2] = 1'b0;
        idle(5);
        do_read(c_BTN,  32'd0, "btn_pulse");
        do_read(c_EDGE, 32'd0, "edge_pulse");

        // Held button: level flips at the 6th edge after assertion
        btn[2] = 1'b1;
        idle(5);
        do_read(c_BTN,  32'd0, "btn_pre");
        do_read(c_BTN,  32'h4, "btn_post");
        do_read(c_EDGE, 32'h4, "edge_set");
        do_write(c_EDGE, 32'h4);
        do_read(c_EDGE, 32'd0, "edge_clr");

        // Clear and new rising edge in the same cycle: set wins
        btn[2] = 1'b0;
        idle(12);
        do_read(c_BTN, 32'd0, "btn_fall");
        btn[2] = 1'b1;
        idle(5);
        do_write(c_EDGE, 32'h4);
        do_read(c_EDGE, 32'h4, "edge_setwins");
        do_write(c_EDGE, 32'h4);
        do_read(c_EDGE, 32'd0, "edge_clr2");

        // Timer compare match
        do_write(c_TIMER, 32'd1000);
        do_write(c_CMP, 32'd100);
        do_write(c_TIMER, 32'd90);
        check("irq_before", 32'(irq), 32'd0);
        for (int j = 1; j <= 11; j++) begin
            @(posedge clk); #1;
            if (j == 9)  check("irq_j9",  32'(irq), 32'd0);
            if (j == 11) check("irq_j11", 32'(irq), 32'd1);
        end
        do_read(c_STATUS, 32'd1, "status_set");
        do_write(c_STATUS, 32'd1);
        check("irq_clr", 32'(irq), 32'd0);

        // Timer wrap
        do_write(c_TIMER, 32'hFFFF_FFFE);
        do_read(c_TIMER, 32'hFFFF_FFFE, "wrap_fe");
        do_read(c_TIMER, 32'hFFFF_FFFF, "wrap_ff");
        do_read(c_TIMER, 32'h0000_0000, "wrap_0");

        // Simultaneous read and write of the same register
        memread   = 1'b1;
        memwrite  = 1'b1;
        addr      = c_LED;
        writedata = 32'h0000_5A5A;
        @(posedge clk); #1;
        memread  = 1'b0;
        memwrite = 1'b0;
        check("rw_old", readdata, 32'h0000_A5A5);
        check("rw_led", 32'(led), 32'h0000_5A5A);

        // readdata holds between reads, miss reads return 0
        do_read(c_CMP, 32'd100, "rd_cmp");
        idle(2);
        check("rd_hold", readdata, 32'd100);
        do_read(32'h0000_1000, 32'd0, "rd_miss");
        do_write(32'h0000_1000, 32'h0000_1111);
        check("wr_miss_hex", 32'(hex), 32'h0000_BEEF);

        // SW is read-only and synchronised
        sw = 16'h1234;
        idle(3);
        do_write(c_SW, 32'hFFFF_FFFF);
        do_read(c_SW, 32'h0000_1234, "sw_ro");

        // Reset in the middle of a write
        memwrite  = 1'b1;
        addr      = c_HEX;
        writedata = 32'h0000_7777;
        #2 reset = 1'b0;
        #1;
        check("midrst_hex", 32'(hex), 32'd0);
        check("midrst_rd", readdata, 32'd0);
        @(posedge clk); #1;
        memwrite = 1'b0;
        check("midrst_hold", 32'(hex), 32'd0);
        reset = 1'b1;
        do_read(c_CMP, 32'hFFFF_FFFF, "midrst_cmp");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
